dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Round-robin arbiter that shares one single-port synchronous data memory between `NUM_C` processor cores. It sits between the per-core load/store ports and the data memory. Each core issues a request/acknowledge transaction. The arbiter serialises the transactions, drives the memory port and returns read data to the winning core. Cores masked off by `core_en` are never granted.

## Interface
Parameters:
- `NUM_C`, 4: number of requesting cores (≥2)
- `AW`, 16: address width
- `DW`, 16: data width

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `core_en`  in  NUM_C  per-core enable; bit i=0 means core i's `req` is ignored
- `req`  in  NUM_C  per-core access request, held until `ack`
- `wr_en`  in  NUM_C  per-core write (1) / read (0) qualifier
- `addr`  in  NUM_C*AW  core i address at `[i*AW +: AW]`
- `wdata`  in  NUM_C*DW  core i write data at `[i*DW +: DW]`
- `gnt`  out  NUM_C  one-hot; high for the core whose access is on the memory port
- `ack`  out  NUM_C  one-hot, one-cycle pulse completing that core's transaction
- `rdata`  out  DW  read data broadcast to all cores, valid when any `ack` is high
- `busy`  out  1  high in ACCESS and RESP
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid one cycle after `mem_en`

## Operation
- FSM states: IDLE, ACCESS, RESP. Internal state: round-robin pointer `ptr` (0..NUM_C-1) and registered winner index `win`.
- Eligible set: `req & core_en`. Winner: first eligible index found searching upward from `ptr`, wrapping from NUM_C-1 to 0.
- IDLE: if the eligible set is non-empty, latch `win`, `wr_en[win]`, `addr[win]` and `wdata[win]`, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS lasts one cycle:
  - `mem_en`=1 and `mem_we`=latched `wr_en`.
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `gnt[win]`=1.
  - Next state is RESP.
- RESP lasts one cycle:
  - `ack[win]`=1.
  - `rdata`=`mem_rdata`. The value is don't-care for writes.
  - `ptr` ← (win+1) mod NUM_C.
  - Arbitration runs again over the eligible set with `win` excluded, searching from (win+1). If a winner is found, latch it and go to ACCESS. Otherwise go to IDLE.
- Requester rules:
  - Hold `req`, `wr_en`, `addr` and `wdata` stable from assertion until `ack`.
  - Deassert `req` or present a new request in the cycle after `ack`.
- If `core_en[i]` clears while core i's access is in ACCESS or RESP, the transaction still completes and is acked.
- The arbiter never issues two accesses for one request.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, ptr=0, win=0. All outputs are 0: `gnt`, `ack`, `busy`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`. Internal state is cleared immediately, regardless of `clk`.
- Reset asserted mid-transaction abandons it with no `ack`. The core re-requests after release.
- All outputs except `rdata` are registered. `rdata` is combinational from `mem_rdata` in RESP and 0 otherwise.
- Latency from IDLE: with `req` sampled high at edge N, ACCESS runs in cycle N+1 and `ack` appears in cycle N+2.
- Back-to-back throughput: one access every 2 cycles (ACCESS, RESP, ACCESS, …).
- Worst-case wait for an eligible, continuously requesting core: 2*(NUM_C-1) cycles after it becomes eligible before its ACCESS.
- Simultaneous requests: strict rotation from `ptr`. No core is granted twice while another eligible core waits.

## Test plan
- Single read: preload mem[0x0040]=0xBEEF; core 1 reads 0x0040. Expect `gnt`=0010 in cycle N+1, `ack[1]` and `rdata`=0xBEEF in N+2, then `busy`=0.
- Write then read: core 0 writes 0x1234 to 0x0010, then core 0 reads 0x0010. Expect `mem_we`=1 with `mem_addr`=0x0010 on the first ACCESS and `rdata`=0x1234 on the second `ack`.
- Contention and wrap: with ptr=0, cores 0, 2 and 3 request together and hold. Acks come in order 0, 2, 3 on cycles 2, 4, 6. Core 0 re-requests; it is granted next, then ptr=1.
- Masking: `core_en`=1101 with all `req` high. Grant order is 0, 2, 3, 0 and core 1 never receives `gnt` or `ack`.
- Disable in flight: clear `core_en[2]` during core 2's ACCESS. `ack[2]` still fires in the next cycle.
- Async reset: pull `rst_n` low mid-ACCESS, between clock edges. All outputs read 0 immediately and there is no `ack`. After release, a held request is served from ptr=0.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// dm_arbiter core-side and memory-side bus bundle.
// slave: arbiter view; master: cores plus memory view.
interface dm_arbiter_if #(
  parameter int NUM_C = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) ();
  logic [NUM_C-1:0]    core_en;
  logic [NUM_C-1:0]    req;
  logic [NUM_C-1:0]    wr_en;
  logic [NUM_C*AW-1:0] addr;
  logic [NUM_C*DW-1:0] wdata;
  logic [NUM_C-1:0]    gnt;
  logic [NUM_C-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  modport slave (
    input  core_en, req, wr_en, addr, wdata,
    input  mem_rdata,
    output gnt, ack, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_en, req, wr_en, addr, wdata,
    output mem_rdata,
    input  gnt, ack, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory
// between NUM_C cores; one access every two cycles.
module dm_arbiter #(
  parameter int NUM_C = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input logic        clk,
  input logic        rst_n,
  dm_arbiter_if.slave bus
);
  localparam int PW = (NUM_C > 1) ? $clog2(NUM_C) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  logic [NUM_C-1:0] gnt_q, ack_q;
  logic             busy_q;
  logic             mem_en_q, mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;

  logic [NUM_C-1:0] elig;
  logic [PW-1:0]    start;
  logic [PW-1:0]    pick;
  logic             found;
  int               s;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] v
  );
    return (v == PW'(NUM_C - 1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [NUM_C-1:0] onehot(
    input logic [PW-1:0] v
  );
    return NUM_C'(1) << v;
  endfunction

  // In RESP the finishing core is still holding req,
  // so it is masked out and the search starts after it.
  always_comb begin
    elig  = bus.req & bus.core_en;
    start = ptr_q;
    if (state_q == S_RESP) begin
      elig[win_q] = 1'b0;
      start       = inc(win_q);
    end
    found = 1'b0;
    pick  = '0;
    s     = 0;
    for (int i = NUM_C - 1; i >= 0; i--) begin
      s = int'(start) + i;
      if (s >= NUM_C) s = s - NUM_C;
      if (elig[PW'(s)]) begin
        found = 1'b1;
        pick  = PW'(s);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: if (found) state_d = S_ACC;
      S_ACC:  state_d = S_RESP;
      S_RESP: begin
        ptr_d   = inc(win_q);
        state_d = found ? S_ACC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ACC) begin
      win_d   = pick;
      we_d    = bus.wr_en[pick];
      addr_d  = bus.addr[int'(pick)*AW +: AW];
      wdata_d = bus.wdata[int'(pick)*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= (state_d == S_ACC)
                     ? onehot(win_d) : '0;
      ack_q       <= (state_d == S_RESP)
                     ? onehot(win_d) : '0;
      busy_q      <= (state_d != S_IDLE);
      mem_en_q    <= (state_d == S_ACC);
      mem_we_q    <= (state_d == S_ACC) && we_d;
      mem_addr_q  <= (state_d == S_ACC)
                     ? addr_d : '0;
      mem_wdata_q <= (state_d == S_ACC)
                     ? wdata_d : '0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = (state_q == S_RESP)
                         ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random
// traffic against a transaction-level round-robin model.
module tb_dm_arbiter;
  localparam int NUM_C = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter_if #(.NUM_C(NUM_C), .AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.NUM_C(NUM_C), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NUM_C-1:0] core_en, req, wr_en, ack_prev;
  logic [AW-1:0]    aa [NUM_C];
  logic [DW-1:0]    dd [NUM_C];
  bit               rand_mode, hold_mode;

  assign bus.core_en = core_en;
  assign bus.req     = req;
  assign bus.wr_en   = wr_en;
  for (genvar g = 0; g < NUM_C; g++) begin : g_pack
    assign bus.addr[g*AW +: AW]  = aa[g];
    assign bus.wdata[g*DW +: DW] = dd[g];
  end

  function automatic logic [DW-1:0] init_val(input logic [7:0] x);
    return (x == 8'h40) ? 16'hBEEF : ({x, ~x} ^ 16'h1357);
  endfunction

  // Memory: contents start as init_val until written
  logic [DW-1:0] mem [256];
  bit            mem_wr [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr[7:0]]    <= bus.mem_wdata;
        mem_wr[bus.mem_addr[7:0]] <= 1'b1;
      end else begin
        bus.mem_rdata <= mem_wr[bus.mem_addr[7:0]]
          ? mem[bus.mem_addr[7:0]] : init_val(bus.mem_addr[7:0]);
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cur = core being served, acc_slot = cycle
  // of its memory access; acks one cycle later, next pick after.
  int            cyc = 0;
  int            rr  = 0;
  int            cur = -1;
  int            acc_slot = -10;
  logic          cur_we;
  logic [AW-1:0] cur_a;
  logic [DW-1:0] cur_d, exp_rd;
  logic [DW-1:0] ref_mem [256];
  bit            ref_wr [256];

  task automatic model_step();
    int c;
    int excl;
    if (!rst_n) return;
    cyc++;
    if (cur >= 0 && cyc == acc_slot + 1) begin
      if (cur_we) begin
        ref_mem[cur_a[7:0]] = cur_d;
        ref_wr[cur_a[7:0]]  = 1'b1;
      end else begin
        exp_rd = ref_wr[cur_a[7:0]] ? ref_mem[cur_a[7:0]]
                                    : init_val(cur_a[7:0]);
      end
    end
    if (cur < 0 || cyc == acc_slot + 2) begin
      excl = -1;
      if (cur >= 0) begin
        rr   = (cur + 1) % NUM_C;
        excl = cur;
        cur  = -1;
      end
      for (int j = 0; j < NUM_C; j++) begin
        c = (rr + j) % NUM_C;
        if (cur < 0 && c != excl && req[c] && core_en[c]) cur = c;
      end
      if (cur >= 0) begin
        acc_slot = cyc;
        cur_we   = wr_en[cur];
        cur_a    = aa[cur];
        cur_d    = dd[cur];
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_C-1:0] eg, ea;
    eg = '0;
    ea = '0;
    if (cur >= 0 && cyc == acc_slot)     eg[cur] = 1'b1;
    if (cur >= 0 && cyc == acc_slot + 1) ea[cur] = 1'b1;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("ack", 32'(bus.ack), 32'(ea));
    chk("busy", 32'(bus.busy), 32'(cur >= 0));
    chk("mem_en", 32'(bus.mem_en), 32'(|eg));
    chk("mem_we", 32'(bus.mem_we), 32'((|eg) & cur_we));
    chk("mem_addr", 32'(bus.mem_addr), (|eg) ? 32'(cur_a) : 32'd0);
    chk("mem_wdata", 32'(bus.mem_wdata), (|eg) ? 32'(cur_d) : 32'd0);
    if (|ea) begin
      if (!cur_we) chk("rdata", 32'(bus.rdata), 32'(exp_rd));
    end else begin
      chk("rdata_idle", 32'(bus.rdata), 32'd0);
    end
  endtask

  task automatic issue(input int i, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]   = 1'b1;
    wr_en[i] = we;
    aa[i]    = a;
    dd[i]    = d;
  endtask

  // Requests drop one cycle after their ack
  task automatic drive();
    for (int i = 0; i < NUM_C; i++) begin
      if (ack_prev[i]) begin
        req[i] = 1'b0;
        if (hold_mode) issue(i, 1'b0, 16'($urandom_range(0, 15)), '0);
      end
    end
    ack_prev = bus.ack;
    if (rand_mode) begin
      for (int i = 0; i < NUM_C; i++)
        if (!req[i] && $urandom_range(0, 2) == 0)
          issue(i, 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 15)), 16'($urandom));
      if ($urandom_range(0, 19) == 0)
        core_en[$urandom_range(0, NUM_C - 1)] ^= 1'b1;
    end
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (req != '0 && n < 60) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    chk("settle_req", 32'(req), 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cur      = -1;
    rr       = 0;
    ack_prev = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    rst_n = 1'b1;
  endtask

  logic [NUM_C-1:0] exp_seq [8];
  logic [NUM_C-1:0] seen;

  initial begin
    core_en   = '1;
    req       = '0;
    wr_en     = '0;
    ack_prev  = '0;
    rand_mode = 1'b0;
    hold_mode = 1'b0;
    for (int i = 0; i < NUM_C; i++) begin
      aa[i] = '0;
      dd[i] = '0;
    end
    exp_seq = '{4'b0000, 4'b0001, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();

    // single read of preloaded word
    issue(1, 1'b0, 16'h0040, '0);
    cycle();
    chk("t1_gnt", 32'(bus.gnt), 32'b0010);
    cycle();
    chk("t1_ack", 32'(bus.ack), 32'b0010);
    chk("t1_rdata", 32'(bus.rdata), 32'hBEEF);
    cycle();
    chk("t1_busy", 32'(bus.busy), 32'd0);
    settle();

    // write then read back
    issue(0, 1'b1, 16'h0010, 16'h1234);
    cycle();
    chk("t2_we", 32'(bus.mem_we), 32'd1);
    chk("t2_addr", 32'(bus.mem_addr), 32'h0010);
    settle();
    issue(0, 1'b0, 16'h0010, '0);
    cycle();
    cycle();
    chk("t2_ack", 32'(bus.ack), 32'b0001);
    chk("t2_rdata", 32'(bus.rdata), 32'h1234);
    settle();

    // contention and wrap from ptr 0
    do_reset();
    issue(0, 1'b0, 16'h0001, '0);
    issue(2, 1'b0, 16'h0002, '0);
    issue(3, 1'b1, 16'h0003, 16'h5555);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t3_ack_seq", 32'(bus.ack), 32'(exp_seq[k]));
      if (k == 3) issue(0, 1'b0, 16'h0003, '0);
    end
    settle();
    issue(0, 1'b0, 16'h0004, '0);
    issue(1, 1'b0, 16'h0005, '0);
    cycle();
    chk("t3_ptr1", 32'(bus.gnt), 32'b0010);
    settle();

    // masking with all requests held
    do_reset();
    core_en   = 4'b1101;
    hold_mode = 1'b1;
    for (int i = 0; i < NUM_C; i++) issue(i, 1'b0, 16'(i), '0);
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t4_ack_seq", 32'(bus.ack), 32'(exp_seq[k]));
      seen |= bus.gnt | bus.ack;
    end
    chk("t4_core1_never", 32'(seen[1]), 32'd0);
    hold_mode = 1'b0;
    core_en   = '1;
    settle();

    // disable in flight
    issue(2, 1'b0, 16'h0007, '0);
    cycle();
    chk("t5_gnt", 32'(bus.gnt), 32'b0100);
    core_en[2] = 1'b0;
    cycle();
    chk("t5_ack", 32'(bus.ack), 32'b0100);
    core_en = '1;
    settle();

    // async reset mid-access
    issue(3, 1'b0, 16'h0008, '0);
    cycle();
    chk("t6_gnt", 32'(bus.gnt), 32'b1000);
    issue(1, 1'b0, 16'h0009, '0);
    #2;
    rst_n    = 1'b0;
    cur      = -1;
    rr       = 0;
    ack_prev = '0;
    #1;
    chk("t6_gnt0", 32'(bus.gnt), 32'd0);
    chk("t6_mem_en0", 32'(bus.mem_en), 32'd0);
    chk("t6_busy0", 32'(bus.busy), 32'd0);
    chk("t6_addr0", 32'(bus.mem_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cycle();
    chk("t6_from_ptr0", 32'(bus.gnt), 32'b0010);
    settle();

    // random traffic
    rand_mode = 1'b1;
    repeat (600) cycle();
    rand_mode = 1'b0;
    core_en   = '1;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
